wbs_patch_assembler: RTL and testbench
======================================

// Module: wbs_patch_assembler
// PURPOSE
//  Sits between the Wishbone slave controller's query-patch port and the query-patch SRAM (single rw port).
//  Bridges 32-bit Wishbone half-word accesses to full 55-bit patches:
//  - writes: stages the lower half and commits the full patch on the upper write;
//  - reads: fetch the whole patch and return the selected half with a one-cycle response pulse.
// PARAMETERS
//  DATA_WIDTH   11                            bits per patch element
//  PATCH_SIZE   5                             elements per patch; PATCH_W = DATA_WIDTH*PATCH_SIZE = 55
//  ROW_SIZE     24                            query rows
//  COL_SIZE     17                            query cols; NUM_QUERYS = ROW_SIZE*COL_SIZE = 408
//  ADDR_W       $clog2(ROW_SIZE*COL_SIZE)     patch address width (9)
// PORTS
//  wb_clk_i      in   1        clock
//  wb_rst_i      in   1        synchronous active-high reset
//  req_valid     in   1        request from controller; held until accepted
//  req_ready     out  1        request accepted on edge where req_valid&&req_ready
//  req_we        in   1        1=write, 0=read
//  req_upper     in   1        0=bits[31:0], 1=bits[PATCH_W-1:32]
//  req_addr      in   ADDR_W   patch index
//  req_wdata     in   32       write data (upper: only [PATCH_W-33:0] used)
//  resp_valid    out  1        one-cycle ack pulse per accepted request
//  resp_rdata    out  32       read half, zero-extended; 0 for writes
//  err_o         out  1        sticky error flag; cleared only by reset
//  mem_csb0      out  1        SRAM chip select, active low
//  mem_web0      out  1        SRAM write enable, active low
//  mem_addr0     out  ADDR_W   SRAM address
//  mem_wdata0    out  PATCH_W  SRAM write patch
//  mem_rdata0    in   PATCH_W  SRAM read patch, valid the cycle after the read strobe edge
// BEHAVIOUR
//  Reset values: req_ready=1, resp_valid=0, resp_rdata=0, err_o=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wdata0=0.
//  Reset also clears the staging register (stg_valid=0, stg_addr=0, stg_lo=0).
//  Reset mid-operation aborts the FSM to IDLE; no SRAM strobe is issued in the cycle after reset.
//  All outputs are registered. req_ready=1 only in IDLE. Accept edge = E0.
//  FSM states: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, RESP (plus RMW_RD, RMW_CAPT under macro).
//  Read (accept E0):
//   - IDLE->RD_ISSUE: csb0=0, web0=1, addr driven.
//   - E1 ->RD_CAPT: strobe off.
//   - E2 ->RESP: resp_rdata = selected half of mem_rdata0, resp_valid=1 for one cycle.
//   - E3 ->IDLE.
//  Lower write: stg_lo=req_wdata, stg_addr=req_addr, stg_valid=1. E0->RESP, ack after E1; no SRAM access.
//   A second lower write overwrites staging.
//  Upper write with stg_valid && stg_addr==req_addr:
//   - E0->WR_ISSUE: csb0=0, web0=0, wdata={req_wdata[PATCH_W-33:0], stg_lo}.
//   - E1->RESP: stg_valid cleared.
//  Upper write without a matching stage: see CONFIGURATION.
//  Reads never forward staged data and leave staging untouched.
//  Out-of-range address (>= NUM_QUERYS), read or write:
//   - no SRAM strobe, no staging change, err_o=1;
//   - ack after E1 with resp_rdata=0.
//  Exactly one resp_valid pulse per accepted request. req fields are sampled only at the accept edge.
// CONFIGURATION
//  WBS_PATCH_RMW_EN undefined (upper write with no matching stage):
//   - commits {upper, stg_lo} with the current stg_lo;
//   - sets err_o; same 2-cycle timing as a matched upper write.
//  WBS_PATCH_RMW_EN defined (upper write with no matching stage):
//   - RMW_RD (read strobe) -> RMW_CAPT;
//   - then WR_ISSUE with {upper, mem_rdata0[31:0]}, preserving the stored lower half;
//   - err_o is not set; ack 4 cycles after accept; staging unchanged.
// TESTING
//  1 reset: hold wb_rst_i 2 cycles -> all outputs at reset values, req_ready=1.
//  2 write addr 2 lower 0x01234567 then upper 0x000BCDEF:
//    -> one SRAM write, addr=2, wdata=55'h0BCDEF_01234567; two resp_valid pulses; err_o=0.
//  3 read addr 1 lower/upper with mem_rdata0=55'h00_1010_DEAD_BEEF
//    -> resp_rdata 0xDEADBEEF, then 0x00001010; each exactly 2 cycles after accept.
//  4 upper write addr 5 after a lower write to addr 4, SRAM[5] holding lower 0xCAFEF00D:
//    -> without macro: err_o=1, write lower=staged addr-4 data;
//    -> with WBS_PATCH_RMW_EN: SRAM[5] lower stays 0xCAFEF00D, err_o=0.
//  5 read addr 408 -> resp_rdata=0, no csb0 low, err_o=1.
//  6 reset asserted during RD_ISSUE of a read:
//    -> no resp_valid; IDLE after release; next request serviced normally.

Source files
------------

// File: rtl/wbs_patch_assembler.sv
// ---------------------------------------------------------------------------
// wbs_patch_assembler
//
// Purpose:
//   Bridges 32-bit Wishbone half-word accesses from the slave controller's
//   query-patch port to a single-port query-patch SRAM holding full
//   PATCH_W-bit patches.
//   - Writes: a lower-half write is staged locally. The matching upper-half
//     write commits {upper, staged lower} to the SRAM in a single write.
//   - Reads: the whole patch is fetched and the selected half is returned,
//     zero-extended, with a one-cycle response pulse.
//   - Out-of-range patch indices never touch the SRAM or the staging
//     register. They set the sticky error flag and are acknowledged with 0.
//
// Optional feature (macro WBS_PATCH_RMW_EN):
//   undefined - an upper write without a matching stage commits
//               {upper, current stg_lo} and sets err_o.
//   defined   - an upper write without a matching stage performs a
//               read-modify-write. The stored lower half is preserved,
//               err_o is not set and staging is left unchanged.
//
// Ports:
//   wb_clk_i    in   clock
//   wb_rst_i    in   synchronous active-high reset
//   req_valid   in   request valid, held until accepted
//   req_ready   out  high only in IDLE; accept = req_valid && req_ready
//   req_we      in   1 = write, 0 = read
//   req_upper   in   0 = patch bits [31:0], 1 = bits [PATCH_W-1:32]
//   req_addr    in   patch index
//   req_wdata   in   write data (upper half uses [PATCH_W-33:0] only)
//   resp_valid  out  one-cycle acknowledge per accepted request
//   resp_rdata  out  read half, zero-extended; 0 for writes and errors
//   err_o       out  sticky error flag, cleared only by reset
//   mem_csb0    out  SRAM chip select, active low
//   mem_web0    out  SRAM write enable, active low
//   mem_addr0   out  SRAM address
//   mem_wdata0  out  SRAM write patch
//   mem_rdata0  in   SRAM read patch, valid the cycle after the read strobe
// ---------------------------------------------------------------------------
module wbs_patch_assembler #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int ADDR_W     = $clog2(ROW_SIZE * COL_SIZE),
  localparam int PATCH_W   = DATA_WIDTH * PATCH_SIZE
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic               req_upper,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               err_o,
  output logic               mem_csb0,
  output logic               mem_web0,
  output logic [ADDR_W-1:0]  mem_addr0,
  output logic [PATCH_W-1:0] mem_wdata0,
  input  logic [PATCH_W-1:0] mem_rdata0
);

  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
  // Width of the upper half of a patch
  localparam int UP_W       = PATCH_W - 32;
  localparam logic [ADDR_W:0] ADDR_LIMIT = NUM_QUERYS[ADDR_W:0];

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_CAPT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
`ifdef WBS_PATCH_RMW_EN
  localparam logic [2:0] S_RMW_RD   = 3'd5;
  localparam logic [2:0] S_RMW_CAPT = 3'd6;
`endif

  logic [2:0]         r_state;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_err;
  logic               r_csb;
  logic               r_web;
  logic [ADDR_W-1:0]  r_maddr;
  logic [PATCH_W-1:0] r_mwdata;

  // Lower-half staging register
  logic               r_stg_valid;
  logic [ADDR_W-1:0]  r_stg_addr;
  logic [31:0]        r_stg_lo;

  // Per-request context captured at the accept edge
  logic               r_upper;
  logic               r_clr_stg;
`ifdef WBS_PATCH_RMW_EN
  logic [UP_W-1:0]    r_upd;
`endif

  logic               w_accept;
  logic               w_oor;
  logic               w_stg_hit;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_oor     = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign w_stg_hit = r_stg_valid && (r_stg_addr == req_addr);

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign err_o      = r_err;
  assign mem_csb0   = r_csb;
  assign mem_web0   = r_web;
  assign mem_addr0  = r_maddr;
  assign mem_wdata0 = r_mwdata;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_err        <= 1'b0;
      r_csb        <= 1'b1;
      r_web        <= 1'b1;
      r_maddr      <= '0;
      r_mwdata     <= '0;
      r_stg_valid  <= 1'b0;
      r_stg_addr   <= '0;
      r_stg_lo     <= '0;
      r_upper      <= 1'b0;
      r_clr_stg    <= 1'b0;
`ifdef WBS_PATCH_RMW_EN
      r_upd        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_resp_rdata <= '0;
            r_upper      <= req_upper;
            r_clr_stg    <= 1'b0;
`ifdef WBS_PATCH_RMW_EN
            r_upd        <= req_wdata[UP_W-1:0];
`endif
            if (w_oor) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else if (!req_we) begin
              r_csb   <= 1'b0;
              r_web   <= 1'b1;
              r_maddr <= req_addr;
              r_state <= S_RD_ISSUE;
            end else if (!req_upper) begin
              r_stg_valid <= 1'b1;
              r_stg_addr  <= req_addr;
              r_stg_lo    <= req_wdata;
              r_state     <= S_RESP;
            end else if (w_stg_hit) begin
              r_csb     <= 1'b0;
              r_web     <= 1'b0;
              r_maddr   <= req_addr;
              r_mwdata  <= {req_wdata[UP_W-1:0], r_stg_lo};
              r_clr_stg <= 1'b1;
              r_state   <= S_WR_ISSUE;
            end else begin
`ifdef WBS_PATCH_RMW_EN
              // Fetch the stored patch first so its lower half survives.
              r_csb   <= 1'b0;
              r_web   <= 1'b1;
              r_maddr <= req_addr;
              r_state <= S_RMW_RD;
`else
              // Unmatched upper write: commit with whatever is staged and flag it.
              r_csb    <= 1'b0;
              r_web    <= 1'b0;
              r_maddr  <= req_addr;
              r_mwdata <= {req_wdata[UP_W-1:0], r_stg_lo};
              r_err    <= 1'b1;
              r_state  <= S_WR_ISSUE;
`endif
            end
          end
        end

        S_RD_ISSUE: begin
          r_csb   <= 1'b1;
          r_state <= S_RD_CAPT;
        end

        S_RD_CAPT: begin
          if (r_upper) begin
            r_resp_rdata <= {{(32 - UP_W){1'b0}}, mem_rdata0[PATCH_W-1:32]};
          end else begin
            r_resp_rdata <= mem_rdata0[31:0];
          end
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end

        S_WR_ISSUE: begin
          r_csb <= 1'b1;
          r_web <= 1'b1;
          if (r_clr_stg) begin
            r_stg_valid <= 1'b0;
          end
          r_state <= S_RESP;
        end

`ifdef WBS_PATCH_RMW_EN
        S_RMW_RD: begin
          r_csb   <= 1'b1;
          r_state <= S_RMW_CAPT;
        end

        S_RMW_CAPT: begin
          r_csb    <= 1'b0;
          r_web    <= 1'b0;
          r_mwdata <= {r_upd, mem_rdata0[31:0]};
          r_state  <= S_WR_ISSUE;
        end
`endif

        // Reads enter with the ack already raised; writes and errors raise
        // it here one cycle later. Either way, leave once it has been shown.
        S_RESP: begin
          if (r_resp_valid) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_resp_valid <= 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_csb        <= 1'b1;
          r_web        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_patch_assembler.sv
module tb_wbs_patch_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_upper = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err_o;
  logic        mem_csb0;
  logic        mem_web0;
  logic [8:0]  mem_addr0;
  logic [54:0] mem_wdata0;
  logic [54:0] mem_rdata0;

  wbs_patch_assembler #(
    .DATA_WIDTH(11),
    .PATCH_SIZE(5),
    .ROW_SIZE(24),
    .COL_SIZE(17)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_upper  (req_upper),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .err_o      (err_o),
    .mem_csb0   (mem_csb0),
    .mem_web0   (mem_web0),
    .mem_addr0  (mem_addr0),
    .mem_wdata0 (mem_wdata0),
    .mem_rdata0 (mem_rdata0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM with a backdoor load port
  logic [54:0] mem [0:511];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [54:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!mem_csb0) begin
      if (!mem_web0) mem[mem_addr0] <= mem_wdata0;
      else mem_rdata0 <= mem[mem_addr0];
    end
  end

  typedef struct { logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [8:0] a; logic [54:0] d; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int n_vec = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_resp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      resp_t e;
      n_resp++;
      if (rq.size() == 0) begin
        chk("unexpected_resp", 64'(resp_rdata), 64'hDEAD_0000_0000_0000);
      end else begin
        e = rq.pop_front();
        chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // SRAM strobe monitor
  always @(negedge clk) begin
    if (!rst && !mem_csb0) begin
      n_strobe++;
      if (!mem_web0) begin
        wr_t w;
        if (wq.size() == 0) begin
          chk("unexpected_write", 64'(mem_addr0), 64'h1_0000);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(mem_addr0), 64'(w.a));
          chk("wr_data", 64'(mem_wdata0), 64'(w.d));
        end
      end
    end
  end

  task automatic load(input logic [8:0] a, input logic [54:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic exp_wr(input logic [8:0] a, input logic [54:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic do_req(input logic we, input logic up, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
    int n;
    resp_t e;
    @(negedge clk);
    req_we = we; req_upper = up; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
    end else begin
      e.rdata = exp_rd;
      e.cyc = cyc + 1 + lat;
      rq.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      // Fields must only matter at the accept edge
      req_addr = '1; req_wdata = 32'hBAD0_BAD0; req_upper = ~up; req_we = ~we;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 64'(rq.size() + wq.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int r0;
    // 1: reset held, preload SRAM meanwhile
    rst = 1'b1;
    load(9'd1,   55'h00_1010_DEAD_BEEF);
    load(9'd5,   {23'h012345, 32'hCAFE_F00D});
    load(9'd6,   {23'h0000AA, 32'h1122_3344});
    load(9'd407, 55'h7F_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_csb", 64'(mem_csb0), 64'd1);
    chk("rst_web", 64'(mem_web0), 64'd1);
    chk("rst_addr", 64'(mem_addr0), 64'd0);
    chk("rst_wdata", 64'(mem_wdata0), 64'd0);
    rst = 1'b0;

    // 2: staged lower + matched upper commit
    do_req(1'b1, 1'b0, 9'd2, 32'h0123_4567, 32'd0, 1);
    exp_wr(9'd2, 55'h0BCDEF_0123_4567);
    do_req(1'b1, 1'b1, 9'd2, 32'h000B_CDEF, 32'd0, 2);
    drain("t2");
    chk("t2_err", 64'(err_o), 64'd0);

    // Second lower write overwrites staging; upper bits above the patch ignored
    do_req(1'b1, 1'b0, 9'd3, 32'hAAAA_5555, 32'd0, 1);
    do_req(1'b1, 1'b0, 9'd3, 32'h1234_5678, 32'd0, 1);
    exp_wr(9'd3, {23'h7FFFFF, 32'h1234_5678});
    do_req(1'b1, 1'b1, 9'd3, 32'hFFFF_FFFF, 32'd0, 2);
    drain("t2b");

    // 3: reads
    do_req(1'b0, 1'b0, 9'd1, 32'd0, 32'hDEAD_BEEF, 2);
    do_req(1'b0, 1'b1, 9'd1, 32'd0, 32'h0000_1010, 2);
    do_req(1'b0, 1'b1, 9'd2, 32'd0, 32'h000B_CDEF, 2);
    do_req(1'b0, 1'b0, 9'd3, 32'd0, 32'h1234_5678, 2);
    do_req(1'b0, 1'b1, 9'd407, 32'd0, 32'h007F_FFFF, 2);
    drain("t3");

    // Reads neither forward nor disturb staging
    do_req(1'b1, 1'b0, 9'd6, 32'h600D_600D, 32'd0, 1);
    do_req(1'b0, 1'b0, 9'd6, 32'd0, 32'h1122_3344, 2);
    exp_wr(9'd6, {23'h000055, 32'h600D_600D});
    do_req(1'b1, 1'b1, 9'd6, 32'h0000_0055, 32'd0, 2);
    drain("t3b");
    chk("t3_err", 64'(err_o), 64'd0);

    // 4: upper write without matching stage
    do_req(1'b1, 1'b0, 9'd4, 32'h4444_4444, 32'd0, 1);
`ifdef WBS_PATCH_RMW_EN
    exp_wr(9'd5, {23'h000ABC, 32'hCAFE_F00D});
    do_req(1'b1, 1'b1, 9'd5, 32'h0000_0ABC, 32'd0, 4);
    drain("t4");
    chk("t4_err", 64'(err_o), 64'd0);
    exp_wr(9'd4, {23'h000001, 32'h4444_4444});
    do_req(1'b1, 1'b1, 9'd4, 32'h0000_0001, 32'd0, 2);
    drain("t4b");
    chk("t4b_err", 64'(err_o), 64'd0);
`else
    exp_wr(9'd5, {23'h000ABC, 32'h4444_4444});
    do_req(1'b1, 1'b1, 9'd5, 32'h0000_0ABC, 32'd0, 2);
    drain("t4");
    chk("t4_err", 64'(err_o), 64'd1);
`endif

    // 5: out-of-range
    s0 = n_strobe;
    do_req(1'b0, 1'b0, 9'd408, 32'd0, 32'd0, 1);
    drain("t5");
    chk("t5_strobes", 64'(n_strobe - s0), 64'd0);
    chk("t5_err", 64'(err_o), 64'd1);
    s0 = n_strobe;
    do_req(1'b1, 1'b0, 9'd511, 32'h5555_AAAA, 32'd0, 1);
    drain("t5b");
    chk("t5b_strobes", 64'(n_strobe - s0), 64'd0);

    // 6: reset during RD_ISSUE
    r0 = n_resp;
    @(negedge clk);
    req_we = 1'b0; req_upper = 1'b0; req_addr = 9'd1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_rst_ready", 64'(req_ready), 64'd1);
    chk("t6_rst_csb", 64'(mem_csb0), 64'd1);
    chk("t6_rst_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_csb", 64'(mem_csb0), 64'd1);
    repeat (5) @(negedge clk);
    chk("t6_no_resp", 64'(n_resp - r0), 64'd0);
    chk("t6_idle", 64'(req_ready), 64'd1);
    do_req(1'b0, 1'b1, 9'd1, 32'd0, 32'h0000_1010, 2);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
